// File: rtl/reg_wb_arbiter.sv
// Generic circular-buffer FIFO with occupancy count; power-of-two DEPTH.
// Latency: pushed word is visible at head_dat the cycle after the push edge.
// Backpressure: none internally; caller must never push when full or pop when empty.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Storage array: data only, pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Writeback arbiter: merges load returns and ALU results onto one registered RF write port.
// Latency: 1 cycle accept-to-WE; queued ALU results wait behind older entries and loads.
// Backpressure: alu_ready drops when the ALU FIFO is full; loads are never stalled.
module reg_wb_arbiter #(
    parameter int ADDR  = 5,
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR-1:0]        alu_rd,
    input  logic [WIDTH-1:0]       alu_data,
    input  logic                   ld_valid,
    input  logic [ADDR-1:0]        ld_rd,
    input  logic [WIDTH-1:0]       ld_data,
    output logic                   WE,
    output logic [ADDR-1:0]        write_address,
    output logic [WIDTH-1:0]       write_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR-1:0]  rd;
        logic [WIDTH-1:0] data;
    } wb_entry_t;

    wb_entry_t        alu_entry;
    wb_entry_t        head;
    logic             alu_live;
    logic             ld_live;
    logic             fifo_nonempty;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             nxt_we;
    logic [ADDR-1:0]  nxt_addr;
    logic [WIDTH-1:0] nxt_data;

    // Ready depends on registered count only, so a same-cycle pop never raises it.
    assign alu_ready     = (fifo_count < CW'(DEPTH));
    assign fifo_nonempty = (fifo_count != '0);
    // Writes to r0 are meaningless; they still complete their handshake but go nowhere.
    assign alu_live      = alu_valid && alu_ready && (alu_rd != '0);
    assign ld_live       = ld_valid && (ld_rd != '0);
    assign alu_entry     = '{rd: alu_rd, data: alu_data};
    // Any live ALU result that did not take the bypass path must be queued.
    assign push          = alu_live && !bypass;
    assign busy          = fifo_nonempty || WE;

    wb_fifo #(
        .W     ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_alu_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (alu_entry),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_count)
    );

    // Port selection: loads first, then queued ALU, then direct ALU bypass; idle holds addr/data.
    always_comb begin
        nxt_we   = 1'b0;
        nxt_addr = write_address;
        nxt_data = write_data;
        pop      = 1'b0;
        bypass   = 1'b0;
        if (ld_live) begin
            nxt_we   = 1'b1;
            nxt_addr = ld_rd;
            nxt_data = ld_data;
        end else if (fifo_nonempty) begin
            nxt_we   = 1'b1;
            nxt_addr = head.rd;
            nxt_data = head.data;
            pop      = 1'b1;
        end else if (alu_live) begin
            nxt_we   = 1'b1;
            nxt_addr = alu_rd;
            nxt_data = alu_data;
            bypass   = 1'b1;
        end
    end

    // Registered write port towards the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WE            <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
        end else begin
            WE            <= nxt_we;
            write_address <= nxt_addr;
            write_data    <= nxt_data;
        end
    end
endmodule
